// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants and FSM encoding for the program fetch stage
package fetch_unit_pkg;

  localparam int          PC_W_DEF     = 16;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;
  localparam logic [7:0]  PORT_RST     = 8'hFF;

  typedef logic [1:0] fetch_state_t;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_LEN   = 2'd1;
  localparam logic [1:0] ST_OPER  = 2'd2;

  // A decoder length of 0 means a single-byte instruction.
  function automatic logic [1:0] eff_len(input logic [1:0] len);
    return (len == 2'd0) ? 2'd1 : len;
  endfunction

endpackage

// File: rtl/fetch_unit_edge_det.sv
// rtl/fetch_unit_edge_det.sv - single-register edge detector for clock-unit strobes
module edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= RST_VAL;
    else        r_q <= i_sig;
  end

  assign o_rise = i_sig & ~r_q;
  assign o_fall = ~i_sig & r_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program fetch and external bus stage: address drive, byte capture, PC advance
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            EA,
  input  logic            ALE,
  input  logic            PSEN,
  input  logic            stall,
  input  logic [1:0]      insn_len,
  input  logic            pc_load,
  input  logic [PC_W-1:0] pc_val,
  input  logic            instr_ack,
  input  logic [7:0]      P0_in,
  input  logic [7:0]      rom_data,
  output logic [7:0]      P0_out,
  output logic            P0_oe,
  output logic [7:0]      P2_out,
  output logic [PC_W-1:0] rom_addr,
  output logic [PC_W-1:0] PC,
  output logic [7:0]      IR,
  output logic [7:0]      op1,
  output logic [7:0]      op2,
  output logic            instr_valid,
  output logic            overrun
);

  logic            w_ale_rise, w_ale_fall, w_psen_rise, w_unused_psen_fall;
  logic            r_stall_d;
  fetch_state_t    r_state;
  logic [1:0]      r_bcnt;
  logic [PC_W-1:0] r_pc, r_rom_addr;
  logic [7:0]      r_ir, r_op1, r_op2, r_p0_out, r_p2_out;
  logic            r_p0_oe, r_instr_valid, r_overrun;

  edge_det #(.RST_VAL(1'b0)) u_ale_det (
    .clk(clk), .rst_n(reset), .i_sig(ALE), .o_rise(w_ale_rise), .o_fall(w_ale_fall)
  );

  // PSEN idles high, so its register resets high to avoid a false rising edge.
  edge_det #(.RST_VAL(1'b1)) u_psen_det (
    .clk(clk), .rst_n(reset), .i_sig(PSEN), .o_rise(w_psen_rise), .o_fall(w_unused_psen_fall)
  );

  logic            w_stalled, w_cap;
  logic [7:0]      w_cap_data;
  logic [1:0]      w_len, w_bcnt_nxt;
  logic [PC_W-1:0] w_pc_inc;
  logic [31:0]     w_pc_ext;

  assign w_stalled  = stall | r_stall_d;
  assign w_cap      = (EA ? w_ale_fall : w_psen_rise) & ~w_stalled & ~pc_load;
  assign w_cap_data = EA ? rom_data : P0_in;
  assign w_len      = eff_len(insn_len);
  assign w_bcnt_nxt = r_bcnt + 2'd1;
  assign w_pc_inc   = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign w_pc_ext   = 32'(r_pc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_stall_d <= 1'b0;
    else        r_stall_d <= stall;
  end

  // Address phase: latched on ALE rise from the PC as it stands before any same-cycle increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_p0_out   <= PORT_RST;
      r_p2_out   <= PORT_RST;
      r_p0_oe    <= 1'b0;
      r_rom_addr <= RESET_PC;
    end else if (w_ale_rise) begin
      r_p0_out   <= w_pc_ext[7:0];
      r_p2_out   <= w_pc_ext[15:8];
      r_rom_addr <= r_pc;
      r_p0_oe    <= ~EA;
    end else if (w_ale_fall) begin
      r_p0_oe    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_FETCH;
      r_bcnt        <= 2'd0;
      r_pc          <= RESET_PC;
      r_ir          <= 8'h00;
      r_op1         <= 8'h00;
      r_op2         <= 8'h00;
      r_instr_valid <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      if (instr_ack) r_instr_valid <= 1'b0;
      if (w_cap && r_instr_valid && !instr_ack) r_overrun <= 1'b1;
      if (pc_load) begin
        r_pc          <= pc_val;
        r_bcnt        <= 2'd0;
        r_state       <= ST_FETCH;
        r_instr_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_FETCH: begin
            if (w_cap) begin
              r_ir    <= w_cap_data;
              r_pc    <= w_pc_inc;
              r_state <= ST_LEN;
            end
          end
          ST_LEN: begin
            if (w_len == 2'd1) begin
              r_instr_valid <= 1'b1;
              r_state       <= ST_FETCH;
            end else begin
              r_bcnt  <= 2'd1;
              r_state <= ST_OPER;
            end
          end
          ST_OPER: begin
            if (w_cap) begin
              if (r_bcnt == 2'd1) r_op1 <= w_cap_data;
              else                r_op2 <= w_cap_data;
              r_pc <= w_pc_inc;
              if (w_bcnt_nxt == w_len) begin
                r_instr_valid <= 1'b1;
                r_bcnt        <= 2'd0;
                r_state       <= ST_FETCH;
              end else begin
                r_bcnt <= w_bcnt_nxt;
              end
            end
          end
          default: r_state <= ST_FETCH;
        endcase
      end
    end
  end

  assign P0_out      = r_p0_out;
  assign P0_oe       = r_p0_oe;
  assign P2_out      = r_p2_out;
  assign rom_addr    = r_rom_addr;
  assign PC          = r_pc;
  assign IR          = r_ir;
  assign op1         = r_op1;
  assign op2         = r_op2;
  assign instr_valid = r_instr_valid;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a byte-stream instruction model
module tb_fetch_unit;

  logic        clk = 1'b0, reset = 1'b0, EA = 1'b1, ALE = 1'b0, PSEN = 1'b1;
  logic        stall = 1'b0, pc_load = 1'b0, instr_ack = 1'b0;
  logic [1:0]  insn_len;
  logic [15:0] pc_val = 16'h0000;
  logic [7:0]  P0_in = 8'h00, rom_data;
  logic [7:0]  P0_out, P2_out, IR, op1, op2;
  logic        P0_oe, instr_valid, overrun;
  logic [15:0] rom_addr, PC;

  logic [7:0]  mem [256];

  fetch_unit dut (
    .clk(clk), .reset(reset), .EA(EA), .ALE(ALE), .PSEN(PSEN), .stall(stall),
    .insn_len(insn_len), .pc_load(pc_load), .pc_val(pc_val), .instr_ack(instr_ack),
    .P0_in(P0_in), .rom_data(rom_data), .P0_out(P0_out), .P0_oe(P0_oe), .P2_out(P2_out),
    .rom_addr(rom_addr), .PC(PC), .IR(IR), .op1(op1), .op2(op2),
    .instr_valid(instr_valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Decoder stand-in: a few fixed opcodes, otherwise the low two bits (0 exercises the len-0 rule).
  function automatic logic [1:0] len_of(input logic [7:0] op);
    case (op)
      8'h74:   return 2'd2;
      8'h02:   return 2'd3;
      8'h00:   return 2'd1;
      default: return op[1:0];
    endcase
  endfunction

  assign insn_len = len_of(IR);
  assign rom_data = mem[rom_addr[7:0]];

  int errors = 0, checks = 0;

  logic [15:0] m_pc;
  logic [7:0]  m_ir, m_op1, m_op2;
  logic        m_valid, m_ovr;
  int          m_pos, m_len;
  logic [7:0]  rise_p0, rise_p2;
  logic        rise_oe, fall_oe;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_ir = 8'h00; m_op1 = 8'h00; m_op2 = 8'h00;
    m_valid = 1'b0; m_ovr = 1'b0; m_pos = 0; m_len = 1;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_valid) m_ovr = 1'b1;
    m_pc = m_pc + 16'd1;
    if (m_pos == 0) begin
      m_ir  = b;
      m_len = (len_of(b) == 2'd0) ? 1 : int'(len_of(b));
    end else if (m_pos == 1) m_op1 = b;
    else m_op2 = b;
    m_pos++;
    if (m_pos == m_len) begin
      m_valid = 1'b1;
      m_pos   = 0;
    end
  endtask

  // One clock-unit machine cycle: ALE pulse, then PSEN pulse; external latch captures P0 at ALE fall.
  task automatic bus_cycle(input bit st, input bit ld, input logic [15:0] ldv);
    stall = st;
    ALE = 1'b1; tick();
    rise_p0 = P0_out; rise_p2 = P2_out; rise_oe = P0_oe;
    tick();
    ALE = 1'b0;
    if (EA && ld) begin pc_load = 1'b1; pc_val = ldv; end
    tick();
    pc_load = 1'b0; fall_oe = P0_oe;
    P0_in = mem[rise_p0]; PSEN = 1'b0; tick(); tick();
    PSEN = 1'b1;
    if (!EA && ld) begin pc_load = 1'b1; pc_val = ldv; end
    tick();
    pc_load = 1'b0; tick();
    stall = 1'b0; tick(); tick();
    if (ld) begin m_pc = ldv; m_pos = 0; m_valid = 1'b0; end
    else if (!st) model_byte(mem[m_pc[7:0]]);
  endtask

  task automatic do_ack();
    instr_ack = 1'b1; tick();
    instr_ack = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic load_pc(input logic [15:0] v);
    pc_load = 1'b1; pc_val = v; tick();
    pc_load = 1'b0;
    m_pc = v; m_pos = 0; m_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0; tick(); tick();
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b0; tick(); tick();
    model_reset();
    checks++;
    if ({PC, IR, op1, op2, instr_valid, overrun} !== {16'h0000, 24'h0, 2'b00}) begin
      errors++;
      $display("FAIL reset_core got PC=%h IR=%h op1=%h op2=%h v=%b ov=%b", PC, IR, op1, op2, instr_valid, overrun);
    end
    checks++;
    if ({P0_out, P0_oe, P2_out, rom_addr} !== {8'hFF, 1'b0, 8'hFF, 16'h0000}) begin
      errors++;
      $display("FAIL reset_bus got P0=%h oe=%b P2=%h rom=%h exp FF 0 FF 0000", P0_out, P0_oe, P2_out, rom_addr);
    end
    reset = 1'b1;
  endtask

  task automatic test_ea1();
    mem[0] = 8'h74; mem[1] = 8'h55;
    EA = 1'b1;
    bus_cycle(0, 0, 0);
    checks++;
    if (rise_oe !== 1'b0 || fall_oe !== 1'b0) begin
      errors++; $display("FAIL ea1_oe got rise=%b fall=%b exp 0 0", rise_oe, fall_oe);
    end
    bus_cycle(0, 0, 0);
    checks++;
    if ({IR, op1, PC, instr_valid, rise_oe} !== {8'h74, 8'h55, 16'h0002, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ea1_insn got IR=%h op1=%h PC=%h v=%b oe=%b exp 74 55 0002 1 0", IR, op1, PC, instr_valid, rise_oe);
    end
  endtask

  task automatic test_ext();
    logic [7:0] exp_lo;
    do_ack();
    load_pc(16'h0000);
    mem[0] = 8'h02; mem[1] = 8'h12; mem[2] = 8'h34;
    EA = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_cycle(0, 0, 0);
      exp_lo = 8'(i);
      checks++;
      if ({rise_p0, rise_p2, rise_oe, fall_oe} !== {exp_lo, 8'h00, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL ext_addr[%0d] got P0=%h P2=%h oe_rise=%b oe_fall=%b exp %h 00 1 0", i, rise_p0, rise_p2, rise_oe, fall_oe, exp_lo);
      end
    end
    checks++;
    if ({IR, op1, op2, PC, instr_valid} !== {8'h02, 8'h12, 8'h34, 16'h0003, 1'b1}) begin
      errors++;
      $display("FAIL ext_insn got IR=%h op1=%h op2=%h PC=%h v=%b exp 02 12 34 0003 1", IR, op1, op2, PC, instr_valid);
    end
  endtask

  task automatic test_wrap();
    do_ack();
    load_pc(16'hFFFF);
    mem[8'hFF] = 8'h00;
    bus_cycle(0, 0, 0);
    checks++;
    if ({PC, IR, instr_valid, rise_p2, rise_p0} !== {16'h0000, 8'h00, 1'b1, 8'hFF, 8'hFF}) begin
      errors++;
      $display("FAIL wrap got PC=%h IR=%h v=%b addr=%h%h exp 0000 00 1 FFFF", PC, IR, instr_valid, rise_p2, rise_p0);
    end
  endtask

  task automatic test_pcload_capture();
    do_ack();
    load_pc(16'h0010);
    mem[8'h10] = 8'h02; mem[8'h11] = 8'hAB; mem[8'h40] = 8'h00;
    EA = 1'b1;
    bus_cycle(0, 0, 0);
    bus_cycle(0, 1, 16'h0040);
    checks++;
    if ({PC, instr_valid, op1} !== {16'h0040, 1'b0, m_op1}) begin
      errors++;
      $display("FAIL load_cap got PC=%h v=%b op1=%h exp 0040 0 %h", PC, instr_valid, op1, m_op1);
    end
    bus_cycle(0, 0, 0);
    checks++;
    if ({IR, PC, instr_valid} !== {8'h00, 16'h0041, 1'b1}) begin
      errors++;
      $display("FAIL load_refetch got IR=%h PC=%h v=%b exp 00 0041 1", IR, PC, instr_valid);
    end
  endtask

  task automatic test_overrun_reset();
    mem[8'h41] = 8'h02; mem[8'h42] = 8'h77;
    EA = 1'b0;
    bus_cycle(0, 0, 0);
    checks++;
    if ({overrun, IR} !== {1'b1, 8'h02}) begin
      errors++; $display("FAIL overrun_set got ov=%b IR=%h exp 1 02", overrun, IR);
    end
    do_ack();
    checks++;
    if ({overrun, instr_valid} !== 2'b10) begin
      errors++; $display("FAIL overrun_sticky got ov=%b v=%b exp 1 0", overrun, instr_valid);
    end
    bus_cycle(0, 0, 0);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({PC, IR, op1, op2, instr_valid, overrun, P0_out, P0_oe, P2_out, rom_addr} !==
        {16'h0000, 24'h0, 2'b00, 8'hFF, 1'b0, 8'hFF, 16'h0000}) begin
      errors++;
      $display("FAIL async_reset got PC=%h IR=%h op1=%h op2=%h v=%b ov=%b P0=%h oe=%b P2=%h rom=%h",
               PC, IR, op1, op2, instr_valid, overrun, P0_out, P0_oe, P2_out, rom_addr);
    end
    tick();
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_stall();
    mem[0] = 8'h5D;
    EA = 1'b0;
    bus_cycle(1, 0, 0);
    checks++;
    if ({PC, IR, instr_valid} !== {16'h0000, 8'h00, 1'b0}) begin
      errors++; $display("FAIL stall got PC=%h IR=%h v=%b exp 0000 00 0", PC, IR, instr_valid);
    end
    bus_cycle(0, 0, 0);
    checks++;
    if ({PC, IR} !== {16'h0001, 8'h5D}) begin
      errors++; $display("FAIL after_stall got PC=%h IR=%h exp 0001 5D", PC, IR);
    end
  endtask

  task automatic test_random();
    logic [15:0] pc_before;
    apply_reset();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int n = 0; n < 60; n++) begin
      EA = 1'($urandom);
      if ($urandom_range(0, 9) == 0) load_pc(16'($urandom_range(0, 200)));
      pc_before = m_pc;
      bus_cycle(($urandom_range(0, 7) == 0), 0, 0);
      checks++;
      if ({rise_p2, rise_p0, rise_oe} !== {pc_before, ~EA}) begin
        errors++;
        $display("FAIL rnd_addr[%0d] got %h%h oe=%b exp %h oe=%b", n, rise_p2, rise_p0, rise_oe, pc_before, ~EA);
      end
      checks++;
      if ({PC, IR, op1, op2, instr_valid, overrun} !== {m_pc, m_ir, m_op1, m_op2, m_valid, m_ovr}) begin
        errors++;
        $display("FAIL rnd_state[%0d] got PC=%h IR=%h op=%h%h v=%b ov=%b exp PC=%h IR=%h op=%h%h v=%b ov=%b",
                 n, PC, IR, op1, op2, instr_valid, overrun, m_pc, m_ir, m_op1, m_op2, m_valid, m_ovr);
      end
      if ($urandom_range(0, 2) != 0) do_ack();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    model_reset();
    test_reset();
    test_ea1();
    test_ext();
    test_wrap();
    test_pcload_capture();
    test_overrun_reset();
    test_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-fetch and external-bus stage directly downstream of the clock unit (Phase/ALE/PSEN generator).
- Drives the program address onto P0/P2 (external ROM, EA=0) or onto rom_addr (internal ROM, EA=1).
- Captures opcode and operand bytes, advances PC, and hands a complete instruction (IR, op1, op2) to decode/execute with a valid/ack handshake.

Parameters:
PC_W, 16, program counter width
RESET_PC, 16'h0000, PC value after reset

Ports:
clk  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-low reset
EA  in  1  1 = internal ROM, 0 = external ROM via P0/P2
ALE  in  1  address latch enable from clock unit
PSEN  in  1  program store enable (active-low) from clock unit
stall  in  1  MOVX/data cycle in progress; suppresses captures
insn_len  in  2  instruction length 1..3 from decoder, decoded from IR
pc_load  in  1  jump/branch: load PC
pc_val  in  PC_W  new PC
instr_ack  in  1  consumer accepted current instruction
P0_in  in  8  port 0 read data
rom_data  in  8  internal ROM data for rom_addr
P0_out  out  8  port 0 address-low drive
P0_oe  out  1  port 0 output enable
P2_out  out  8  port 2 address-high drive
rom_addr  out  PC_W  internal ROM address
PC  out  PC_W  address of next byte to fetch
IR  out  8  opcode
op1  out  8  first operand byte
op2  out  8  second operand byte
instr_valid  out  1  IR/op1/op2 hold a complete instruction
overrun  out  1  sticky: byte captured while instr_valid unacked

Behaviour:
- Reset (reset=0, async): PC=RESET_PC, IR=op1=op2=0, P0_out=8'hFF, P0_oe=0, P2_out=8'hFF, rom_addr=RESET_PC, instr_valid=0, overrun=0, bcnt=0, state=FETCH. Reset mid-instruction discards all partial bytes.
- ALE, PSEN and stall are registered once (ale_d, psen_d, stall_d); edges detected from the registered values.
- ale_rise: P0_out=PC[7:0], P2_out=PC[15:8], rom_addr=PC; P0_oe=~EA.
- ale_fall: P0_oe=0, releasing P0 for data.
- Capture event: EA ? ale_fall : (psen_d==0 && PSEN==1). Capture data: EA ? rom_data : P0_in, sampled in the same cycle as the event.
- Captures are ignored while stall=1; PC is held.
- States: FETCH, LEN, OPER.
  - FETCH: on capture, IR<=data, PC<=PC+1, go to LEN.
  - LEN (exactly 1 cycle; decoder sees new IR): if insn_len<=1, assert instr_valid and return to FETCH; else bcnt=1, go to OPER.
  - OPER: on capture, bcnt==1 -> op1, bcnt==2 -> op2; PC<=PC+1. If bcnt+1==insn_len: assert instr_valid, bcnt=0, go to FETCH; else bcnt+1.
- Operand registers not written by the current instruction keep their previous values.
- PC arithmetic is modulo 2^PC_W: FFFF+1 -> 0000.
- instr_valid stays high until the cycle instr_ack=1, then clears; ack while not valid is ignored.
- A capture while instr_valid=1 and instr_ack=0 sets overrun (sticky until reset). The byte is still stored and the FSM still advances.
- pc_load has highest priority: PC=pc_val, bcnt=0, state=FETCH, instr_valid=0. A capture in the same cycle is discarded; ALE-driven outputs are not disturbed.
- ale_rise and a capture in the same cycle: the address uses PC before the increment.
- insn_len=0 is treated as 1.

Decomposition:
- Shared package: FSM state encoding (FETCH/LEN/OPER), RESET_PC, PC_W, port reset constant 8'hFF.
- One natural sub-module: edge_det (register plus rise/fall outputs), instantiated for ALE and PSEN.

Test Plan:
- EA=1, rom 0x0000=0x74, 0x0001=0x55, insn_len=2 -> instr_valid with IR=74, op1=55, PC=0002, P0_oe never 1.
- EA=0, P0_in=0x02 then 0x12, 0x34, insn_len=3 -> P0_out=00/01/02 on successive ale_rise, P2_out=00, P0_oe drops on ale_fall, result IR=02, op1=12, op2=34, PC=0003.
- pc_load with pc_val=FFFF, 1-byte op 0x00 -> PC wraps to 0000, instr_valid=1.
- pc_load asserted in the same cycle as an operand capture -> byte discarded, state=FETCH, instr_valid=0, PC=pc_val.
- instr_ack held 0 across the next capture -> overrun=1 and stays 1 after ack; async reset low mid-OPER -> all outputs at reset values immediately.
- stall=1 across a PSEN pulse (EA=0) -> no capture, PC unchanged.
